// File: rtl/pipeline_ctrl_defs.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_defs;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  localparam int LOAD_BIT = 3;

  // Hazard sources, highest priority first.
  typedef enum logic [2:0] {
    PRI_NONE,
    PRI_DMEM,
    PRI_MD,
    PRI_BRANCH,
    PRI_LOAD_USE,
    PRI_IMEM
  } prio_t;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(8'b0000_1111);

  // A register that is frozen must not also take a bubble.
  function automatic ctrl_t hold_wins(ctrl_t c);
    ctrl_t r;
    r = c;
    r.if_id_flush  = c.if_id_flush  & ~c.if_id_hold;
    r.id_ex_flush  = c.id_ex_flush  & ~c.id_ex_hold;
    r.ex_mem_flush = c.ex_mem_flush & ~c.ex_mem_hold;
    return r;
  endfunction

  function automatic logic src_hit(
    logic       uses,
    logic [4:0] rs,
    logic [4:0] rd
  );
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] COUNT
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (CLR) begin
      count_d = '0;
    end else if (INC && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign COUNT = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline, including the
// M-unit start/done handshake and the stall/flush event counters.
import pipeline_ctrl_defs::*;

module pipeline_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_REG_READ_ADDR1,
  input  logic [4:0]       ID_REG_READ_ADDR2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [3:0]       EX_DATA_MEM_READ,
  input  logic [4:0]       EX_REG_WRITE_ADDR,
  input  logic             EX_MD_REQ,
  input  logic             MD_DONE,
  input  logic             BRANCH_TAKEN,
  input  logic             INST_MEM_BUSY,
  input  logic             DATA_MEM_BUSY,
  input  logic             CNT_CLEAR,
  output logic             PC_HOLD,
  output logic             IF_ID_HOLD,
  output logic             ID_EX_HOLD,
  output logic             EX_MEM_HOLD,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             MD_START,
  output logic             MD_ERROR,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] FLUSH_EVENTS
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          md_err_q, md_err_d;

  prio_t prio;
  ctrl_t ctrl_raw;
  ctrl_t ctrl;
  logic  md_start_raw;
  logic  md_stall;
  logic  load_use;
  logic  br_take;
  logic  unused_ok;

  assign unused_ok = ^EX_DATA_MEM_READ;

  assign load_use = EX_DATA_MEM_READ[LOAD_BIT]
    && (EX_REG_WRITE_ADDR != 5'd0)
    && (src_hit(ID_USES_RS1, ID_REG_READ_ADDR1, EX_REG_WRITE_ADDR)
     || src_hit(ID_USES_RS2, ID_REG_READ_ADDR2, EX_REG_WRITE_ADDR));

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    md_err_d     = md_err_q;
    md_start_raw = 1'b0;
    md_stall     = 1'b0;
    prio         = PRI_NONE;
    if (DATA_MEM_BUSY) begin
      prio = PRI_DMEM;
    end else begin
      if (state_q == ST_RUN) begin
        if (EX_MD_REQ) begin
          md_start_raw = 1'b1;
          if (!MD_DONE) begin
            md_stall = 1'b1;
            state_d  = ST_MD_WAIT;
            tmo_d    = '0;
          end
        end
      end else if (MD_DONE) begin
        state_d = ST_RUN;
        tmo_d   = '0;
      end else if (tmo_q == TMO_LAST) begin
        // Give up on the M-unit and let the pipeline drain.
        md_err_d = 1'b1;
        state_d  = ST_RUN;
        tmo_d    = '0;
      end else begin
        md_stall = 1'b1;
        tmo_d    = tmo_q + 1'b1;
      end
      if (md_stall) begin
        prio = PRI_MD;
      end else if (BRANCH_TAKEN) begin
        prio = PRI_BRANCH;
      end else if (load_use) begin
        prio = PRI_LOAD_USE;
      end else if (INST_MEM_BUSY) begin
        prio = PRI_IMEM;
      end
    end
  end

  always_comb begin
    ctrl_raw = CTRL_IDLE;
    unique case (prio)
      PRI_DMEM: begin
        ctrl_raw.pc_hold      = 1'b1;
        ctrl_raw.if_id_hold   = 1'b1;
        ctrl_raw.id_ex_hold   = 1'b1;
        ctrl_raw.ex_mem_hold  = 1'b1;
        ctrl_raw.mem_wb_flush = 1'b1;
      end
      PRI_MD: begin
        ctrl_raw.pc_hold      = 1'b1;
        ctrl_raw.if_id_hold   = 1'b1;
        ctrl_raw.id_ex_hold   = 1'b1;
        ctrl_raw.ex_mem_flush = 1'b1;
      end
      PRI_BRANCH: begin
        ctrl_raw.if_id_flush = 1'b1;
        ctrl_raw.id_ex_flush = 1'b1;
      end
      PRI_LOAD_USE: begin
        ctrl_raw.pc_hold     = 1'b1;
        ctrl_raw.if_id_hold  = 1'b1;
        ctrl_raw.id_ex_flush = 1'b1;
      end
      PRI_IMEM: begin
        ctrl_raw.pc_hold     = 1'b1;
        ctrl_raw.if_id_flush = 1'b1;
      end
      default: ctrl_raw = CTRL_IDLE;
    endcase
  end

  always_comb begin
    ctrl     = hold_wins(ctrl_raw);
    MD_START = md_start_raw;
    br_take  = (prio == PRI_BRANCH);
    if (!RESET) begin
      ctrl     = CTRL_BUBBLE;
      MD_START = 1'b0;
      br_take  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_RUN;
      tmo_q    <= '0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      md_err_q <= md_err_d;
    end
  end

  assign PC_HOLD      = ctrl.pc_hold;
  assign IF_ID_HOLD   = ctrl.if_id_hold;
  assign ID_EX_HOLD   = ctrl.id_ex_hold;
  assign EX_MEM_HOLD  = ctrl.ex_mem_hold;
  assign IF_ID_FLUSH  = ctrl.if_id_flush;
  assign ID_EX_FLUSH  = ctrl.id_ex_flush;
  assign EX_MEM_FLUSH = ctrl.ex_mem_flush;
  assign MEM_WB_FLUSH = ctrl.mem_wb_flush;
  assign MD_ERROR     = md_err_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (CNT_CLEAR),
    .INC  (ctrl.pc_hold),
    .COUNT(STALL_CYCLES)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (CNT_CLEAR),
    .INC  (br_take),
    .COUNT(FLUSH_EVENTS)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    a1, a2, rd;
  logic          u1, u2;
  logic [3:0]    ld;
  logic          md_req, md_done, br, ibusy, dbusy, cclr;
  logic          pc_h, ifid_h, idex_h, exmem_h;
  logic          ifid_f, idex_f, exmem_f, memwb_f;
  logic          md_start, md_err;
  logic [CW-1:0] stalls, flushes;
  logic [8:0]    ctl;

  int total = 0;
  int bad   = 0;

  // Bit order: PC,IFID,IDEX,EXMEM holds | IFID,IDEX,EXMEM,MEMWB flushes | START
  localparam logic [8:0] C_IDLE = 9'b0000_0000_0;
  localparam logic [8:0] C_RST  = 9'b0000_1111_0;
  localparam logic [8:0] C_LU   = 9'b1100_0100_0;
  localparam logic [8:0] C_MDS  = 9'b1110_0010_1;
  localparam logic [8:0] C_MDW  = 9'b1110_0010_0;
  localparam logic [8:0] C_MUL  = 9'b0000_0000_1;
  localparam logic [8:0] C_DMEM = 9'b1111_0001_0;
  localparam logic [8:0] C_BR   = 9'b0000_1100_0;
  localparam logic [8:0] C_IMEM = 9'b1000_1000_0;

  assign ctl = {pc_h, ifid_h, idex_h, exmem_h,
                ifid_f, idex_f, exmem_f, memwb_f, md_start};

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .MD_TIMEOUT(4),
    .CNT_W     (CW)
  ) dut (
    .CLK              (clk),
    .RESET            (rst_n),
    .ID_REG_READ_ADDR1(a1),
    .ID_REG_READ_ADDR2(a2),
    .ID_USES_RS1      (u1),
    .ID_USES_RS2      (u2),
    .EX_DATA_MEM_READ (ld),
    .EX_REG_WRITE_ADDR(rd),
    .EX_MD_REQ        (md_req),
    .MD_DONE          (md_done),
    .BRANCH_TAKEN     (br),
    .INST_MEM_BUSY    (ibusy),
    .DATA_MEM_BUSY    (dbusy),
    .CNT_CLEAR        (cclr),
    .PC_HOLD          (pc_h),
    .IF_ID_HOLD       (ifid_h),
    .ID_EX_HOLD       (idex_h),
    .EX_MEM_HOLD      (exmem_h),
    .IF_ID_FLUSH      (ifid_f),
    .ID_EX_FLUSH      (idex_f),
    .EX_MEM_FLUSH     (exmem_f),
    .MEM_WB_FLUSH     (memwb_f),
    .MD_START         (md_start),
    .MD_ERROR         (md_err),
    .STALL_CYCLES     (stalls),
    .FLUSH_EVENTS     (flushes)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    a1 = 5'd0; a2 = 5'd0; rd = 5'd0; u1 = 1'b0; u2 = 1'b0;
    ld = 4'd0; md_req = 1'b0; md_done = 1'b0; br = 1'b0;
    ibusy = 1'b0; dbusy = 1'b0; cclr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    #2;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_stall", 32'(stalls), 0);
    chk("rst_flush", 32'(flushes), 0);
    chk("rst_err", 32'(md_err), 0);

    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Load-use on rs2 = x5
    @(negedge clk);
    ld = 4'b1000; rd = 5'd5; a1 = 5'd3; u1 = 1'b1; a2 = 5'd5; u2 = 1'b1; #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LU));
    @(negedge clk); idle_in(); #1;
    chk("lu_after", 32'(ctl), 32'(C_IDLE));
    chk("lu_stalls", 32'(stalls), 1);

    // Load to x0 never stalls
    @(negedge clk); ld = 4'b1000; rd = 5'd0; a2 = 5'd0; u2 = 1'b1; #1;
    chk("lu_x0", 32'(ctl), 32'(C_IDLE));
    // Matching address but rs2 unused
    @(negedge clk); rd = 5'd7; a2 = 5'd7; u2 = 1'b0; #1;
    chk("lu_unused", 32'(ctl), 32'(C_IDLE));
    // Match on rs1
    @(negedge clk); a1 = 5'd7; u1 = 1'b1; #1;
    chk("lu_rs1", 32'(ctl), 32'(C_LU));

    @(negedge clk); idle_in(); cclr = 1'b1; #1;
    @(negedge clk); cclr = 1'b0; #1;
    chk("clr_stalls", 32'(stalls), 0);

    // DIV: done three cycles after start
    @(negedge clk); md_req = 1'b1; #1;
    chk("div_c0", 32'(ctl), 32'(C_MDS));
    @(negedge clk); #1;
    chk("div_c1", 32'(ctl), 32'(C_MDW));
    @(negedge clk); #1;
    chk("div_c2", 32'(ctl), 32'(C_MDW));
    @(negedge clk); md_done = 1'b1; #1;
    chk("div_done", 32'(ctl), 32'(C_IDLE));
    @(negedge clk); md_req = 1'b0; md_done = 1'b0; #1;
    chk("div_after", 32'(ctl), 32'(C_IDLE));
    chk("div_stalls", 32'(stalls), 3);

    // MUL with same-cycle done
    @(negedge clk); md_req = 1'b1; md_done = 1'b1; #1;
    chk("mul_ctl", 32'(ctl), 32'(C_MUL));
    @(negedge clk); md_req = 1'b0; md_done = 1'b0; #1;
    chk("mul_stalls", 32'(stalls), 3);

    // Timeout after 4 stalled cycles
    @(negedge clk); md_req = 1'b1; #1;
    chk("tmo_c0", 32'(ctl), 32'(C_MDS));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1;
      chk("tmo_wait", 32'(ctl), 32'(C_MDW));
    end
    @(negedge clk); #1;
    chk("tmo_release", 32'(ctl), 32'(C_IDLE));
    chk("tmo_err_pre", 32'(md_err), 0);
    @(negedge clk); md_req = 1'b0; #1;
    chk("tmo_err", 32'(md_err), 1);
    chk("tmo_stalls", 32'(stalls), 7);

    // Branch deferred by two busy data-memory cycles
    @(negedge clk); dbusy = 1'b1; br = 1'b1; #1;
    chk("brb_c0", 32'(ctl), 32'(C_DMEM));
    @(negedge clk); #1;
    chk("brb_c1", 32'(ctl), 32'(C_DMEM));
    chk("brb_fe0", 32'(flushes), 0);
    @(negedge clk); dbusy = 1'b0; #1;
    chk("brb_c2", 32'(ctl), 32'(C_BR));
    @(negedge clk); br = 1'b0; #1;
    chk("brb_c3", 32'(ctl), 32'(C_IDLE));
    chk("brb_fe", 32'(flushes), 1);
    chk("brb_stalls", 32'(stalls), 9);

    // Load-use together with instruction-memory busy
    @(negedge clk);
    ld = 4'b1000; rd = 5'd9; a1 = 5'd9; u1 = 1'b1; ibusy = 1'b1; #1;
    chk("lu_imem", 32'(ctl), 32'(C_LU));
    @(negedge clk); idle_in(); ibusy = 1'b1; #1;
    chk("imem", 32'(ctl), 32'(C_IMEM));
    // M request while data memory busy: no start
    @(negedge clk); ibusy = 1'b0; dbusy = 1'b1; md_req = 1'b1; #1;
    chk("dmem_md", 32'(ctl), 32'(C_DMEM));
    @(negedge clk); idle_in(); #1;
    chk("dmem_md_st", 32'(stalls), 12);
    chk("err_sticky", 32'(md_err), 1);

    // Saturation, then clear overriding an increment
    @(negedge clk); dbusy = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("sat_stalls", 32'(stalls), 15);
    cclr = 1'b1;
    @(negedge clk); idle_in(); #1;
    chk("clr_ovr", 32'(stalls), 0);
    chk("clr_fe", 32'(flushes), 0);

    // Reset in the middle of an M wait
    @(negedge clk); md_req = 1'b1; #1;
    chk("rmd_c0", 32'(ctl), 32'(C_MDS));
    @(negedge clk); #1;
    chk("rmd_c1", 32'(ctl), 32'(C_MDW));
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rmd_ctl", 32'(ctl), 32'(C_RST));
    chk("rmd_err", 32'(md_err), 0);
    chk("rmd_st", 32'(stalls), 0);
    @(negedge clk); rst_n = 1'b1; md_req = 1'b0; #1;
    chk("rmd_idle", 32'(ctl), 32'(C_IDLE));
    @(negedge clk); md_req = 1'b1; #1;
    chk("rmd_run", 32'(ctl), 32'(C_MDS));
    @(negedge clk); md_done = 1'b1; #1;
    chk("rmd_done", 32'(ctl), 32'(C_IDLE));
    @(negedge clk); idle_in(); #1;
    chk("rmd_stalls", 32'(stalls), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
